i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter: SCK_HALF, default 1, tb_clk cycles per SCK half-period, legal range 1..255.
REQ-002 SHALL have port: tb_clk  in  1  sole system clock; all logic on its rising edge.
REQ-003 SHALL have port: tb_n_rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: tx_en  in  1  transmit enable.
REQ-005 SHALL have port: tx_data  in  32  sample; [31:16] left channel, [15:0] right channel.
REQ-006 SHALL have port: tx_valid  in  1  tx_data valid.
REQ-007 SHALL have port: tx_ready  out  1  holding buffer empty, can accept a sample.
REQ-008 SHALL have port: sck  out  1  serial bit clock.
REQ-009 SHALL have port: ws  out  1  word select: 0 = left, 1 = right.
REQ-010 SHALL have port: serial_data_out  out  1  serial data, MSB first.
REQ-011 SHALL have port: underrun  out  1  one-cycle pulse when a frame starts with the holding buffer empty.

Function
REQ-012 SHALL register all outputs; tx_ready SHALL equal !buf_full.
REQ-013 SHALL write tx_data into a one-deep holding buffer on any tb_clk edge where tx_valid && tx_ready, and set buf_full.
REQ-014 SHALL use FSM states IDLE and SHIFT.
REQ-015 SHALL hold sck=0, ws=1 and serial_data_out=0 in IDLE, with divider and slot counter cleared.
REQ-016 SHALL move IDLE->SHIFT on the first edge with tx_en && buf_full, entering lead-in slot 31 with sck=0, ws=0, serial_data_out=0 and the shift register cleared.
REQ-017 SHALL, in SHIFT, count a divider 0..SCK_HALF-1 and toggle sck at terminal count, giving an SCK period of 2*SCK_HALF tb_clk cycles.
REQ-018 SHALL, on each sck 1->0 toggle (falling edge), advance the slot counter mod 32 and update ws and serial_data_out in that same cycle; both SHALL otherwise be stable.
REQ-019 SHALL output shift[31-k] during slot k, and ws=0 for slots 31 and 0..14, ws=1 for slots 15..30 (one-bit I2S delay).
REQ-020 SHALL, on each slot 31->0 advance with buf_full=1, load the shift register from the buffer and clear buf_full; tx_ready SHALL rise the next cycle.
REQ-021 SHALL, on each slot 31->0 advance with buf_full=0, load zeros and pulse underrun for exactly one tb_clk cycle.
REQ-022 SHALL, on a simultaneous underrun load and handshake, accept the sample into the buffer for the next frame while the current frame remains zeros.
REQ-023 SHALL sample tx_en only at slot 31->0 advance; if tx_en=0 there, return to IDLE instead of loading, so an in-flight frame always completes.
REQ-024 SHALL permit tx_valid/tx_data to change freely while tx_ready=0 without effect.

Reset
REQ-025 SHALL, on tb_n_rst=0, immediately force: state IDLE, sck=0, ws=1, serial_data_out=0, tx_ready=1, underrun=0, buffer/shift/counters cleared, independent of tb_clk.
REQ-026 SHALL discard a partial frame on reset mid-frame and resume only via REQ-016 after release.

Verification
REQ-027 SHALL cover reset: assert tb_n_rst=0 between edges -> outputs reach REQ-025 values with no clock edge; tx_ready=1.
REQ-028 SHALL cover single frame: SCK_HALF=1, tx_en=1, one sample 0xA5A5_0F0F -> after a 2-cycle lead-in, left bits 1010010110100101 and right 0000111100001111 MSB-first on falling edges; ws low in slots 31,0..14; frame = 64 tb_clk; tx_ready=1 the cycle after the load.
REQ-029 SHALL cover streaming: SCK_HALF=3, samples 0x12345678, 0x9ABCDEF0, 0x0000FFFF fed whenever tx_ready -> contiguous frames of 192 tb_clk, no underrun, bit-exact stream.
REQ-030 SHALL cover underrun: one sample then tx_valid=0 -> second frame all zeros, underrun high exactly 1 cycle at its slot 0, ws continues toggling.
REQ-031 SHALL cover disable: tx_en falls in slot 5 -> frame completes through slot 31, then IDLE with ws=1, sck=0, serial_data_out=0.
REQ-032 SHALL cover reset mid-frame: reset at slot 20 -> REQ-025 values; after release with buffer refilled, a fresh lead-in precedes the new frame.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep sample buffer feeding a 32-slot stereo frame.
// Each frame starts with one lead-in slot, then left/right MSB-first with the standard one-bit ws delay.
module i2s_tx #(
  parameter int unsigned SCK_HALF = 1
) (
  input  logic        tb_clk,
  input  logic        tb_n_rst,
  input  logic        tx_en,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        sck,
  output logic        ws,
  output logic        serial_data_out,
  output logic        underrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [7:0] DIV_TC = 8'(SCK_HALF - 1);

  state_t      state;
  logic [7:0]  div;
  logic [4:0]  slot;
  logic [31:0] hold;
  logic [31:0] shift;
  logic        full;

  logic       fall, wrap, take, load, full_nxt;
  logic [4:0] nslot;

  always_comb begin
    fall     = (state == SHIFT) && (div == DIV_TC) && sck;
    wrap     = fall && (slot == 5'd31);
    take     = tx_valid && tx_ready;
    load     = wrap && tx_en && full;
    nslot    = slot + 5'd1;
    // take and load never coincide: take needs an empty buffer, load a full one
    full_nxt = take ? 1'b1 : (load ? 1'b0 : full);
  end

  always_ff @(posedge tb_clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      state           <= IDLE;
      div             <= '0;
      slot            <= '0;
      hold            <= '0;
      shift           <= '0;
      full            <= 1'b0;
      tx_ready        <= 1'b1;
      sck             <= 1'b0;
      ws              <= 1'b1;
      serial_data_out <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      underrun <= 1'b0;
      full     <= full_nxt;
      tx_ready <= !full_nxt;
      if (take) hold <= tx_data;
      case (state)
        IDLE: begin
          if (tx_en && full) begin
            state           <= SHIFT;
            slot            <= 5'd31;
            div             <= '0;
            sck             <= 1'b0;
            ws              <= 1'b0;
            serial_data_out <= 1'b0;
            shift           <= '0;
          end
        end
        SHIFT: begin
          if (div == DIV_TC) begin
            div <= '0;
            sck <= ~sck;
            if (wrap && !tx_en) begin
              // in-flight frame is done; park the bus
              state           <= IDLE;
              slot            <= '0;
              sck             <= 1'b0;
              ws              <= 1'b1;
              serial_data_out <= 1'b0;
            end else if (wrap) begin
              slot <= '0;
              ws   <= 1'b0;
              if (full) begin
                shift           <= hold;
                serial_data_out <= hold[31];
              end else begin
                shift           <= '0;
                serial_data_out <= 1'b0;
                underrun        <= 1'b1;
              end
            end else if (fall) begin
              slot            <= nslot;
              ws              <= (nslot >= 5'd15) && (nslot <= 5'd30);
              serial_data_out <= shift[5'd31 - nslot];
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (SCK_HALF 1 and 3), a frame decoder per instance
// and a shared queue of expected frame words.
module tb_i2s_tx;
  logic        tb_clk = 1'b0;
  logic        tb_n_rst = 1'b1;
  logic [1:0]  tx_en = '0, tx_valid = '0;
  logic [1:0]  tx_ready, sck, ws, sdo, underrun;
  logic [31:0] tx_data [2];

  int          n_chk = 0, n_fail = 0;
  logic [31:0] expq [$];
  int          cyc = 0, nfr = 0;
  int          ucnt [2], uat0 [2];

  always #5 tb_clk = ~tb_clk;

  i2s_tx #(.SCK_HALF(1)) u_dut1 (
    .tb_clk(tb_clk), .tb_n_rst(tb_n_rst), .tx_en(tx_en[0]), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .sck(sck[0]), .ws(ws[0]),
    .serial_data_out(sdo[0]), .underrun(underrun[0]));

  i2s_tx #(.SCK_HALF(3)) u_dut3 (
    .tb_clk(tb_clk), .tb_n_rst(tb_n_rst), .tx_en(tx_en[1]), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .sck(sck[1]), .ws(ws[1]),
    .serial_data_out(sdo[1]), .underrun(underrun[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int hf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Frame decoder: a ws fall opens a frame, next 32 sck falls carry its bits.
  logic [1:0]  psck = '0, pws = '1;
  logic        col [2];
  int          cnt [2], fst [2];
  logic [31:0] word [2], wsv [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      col[i] = 1'b0; cnt[i] = 0; fst[i] = 0; ucnt[i] = 0; uat0[i] = 0;
      tx_data[i] = '0;
    end
  end

  always begin
    @(negedge tb_clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!tb_n_rst) begin
        col[i] = 1'b0;
      end else begin
        if (underrun[i]) begin
          ucnt[i]++;
          if (psck[i] && !sck[i] && col[i] && cnt[i] == 0) uat0[i]++;
        end
        if (psck[i] && !sck[i] && col[i]) begin
          if (cnt[i] == 0 && ws[i]) begin
            col[i] = 1'b0;  // sck drop on return to IDLE, not a data bit
          end else begin
            if (cnt[i] == 0) begin
              chk("lead_in", cyc - fst[i], 2 * hf(i));
              chk("rdy_at_load", {31'd0, tx_ready[i]}, 32'd1);
            end
            word[i] = {word[i][30:0], sdo[i]};
            wsv[i]  = {wsv[i][30:0], ws[i]};
            cnt[i]++;
            if (cnt[i] == 32) begin
              col[i] = 1'b0;
              nfr++;
              chk("frame_len", cyc - fst[i], 64 * hf(i));
              chk("ws_pattern", wsv[i], 32'h0001FFFE);
              if (expq.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
              else chk("frame_data", word[i], expq.pop_front());
            end
          end
        end
        if (pws[i] && !ws[i]) begin
          col[i] = 1'b1; cnt[i] = 0; fst[i] = cyc;
        end
      end
      psck[i] = sck[i];
      pws[i]  = ws[i];
    end
  end

  task automatic check_rst(input int i);
    chk("rst_sck", {31'd0, sck[i]}, 32'd0);
    chk("rst_ws", {31'd0, ws[i]}, 32'd1);
    chk("rst_sdo", {31'd0, sdo[i]}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready[i]}, 32'd1);
    chk("rst_underrun", {31'd0, underrun[i]}, 32'd0);
  endtask

  // Garbage with valid=1 while not ready must be ignored; real data only once ready is seen.
  task automatic send(input int i, input logic [31:0] d);
    int k = 0;
    @(negedge tb_clk);
    while (!tx_ready[i] && k < 3000) begin
      tx_valid[i] = 1'b1;
      tx_data[i]  = $urandom;
      @(negedge tb_clk);
      k++;
    end
    if (!tx_ready[i]) chk("send_timeout", 32'd0, 32'd1);
    tx_valid[i] = 1'b1;
    tx_data[i]  = d;
    @(posedge tb_clk);
    #1 tx_valid[i] = 1'b0;
    tx_data[i] = $urandom;
    expq.push_back(d);
  endtask

  task automatic wait_rdy(input int i);
    int k = 0;
    do begin
      @(negedge tb_clk);
      k++;
    end while (!tx_ready[i] && k < 3000);
    if (!tx_ready[i]) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int i);
    int k = 0;
    while (expq.size() != 0 && k < 6000) begin
      @(negedge tb_clk);
      k++;
    end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 32'd0);
    repeat (4 * hf(i)) @(negedge tb_clk);
    chk("idle_sck", {31'd0, sck[i]}, 32'd0);
    chk("idle_ws", {31'd0, ws[i]}, 32'd1);
    chk("idle_sdo", {31'd0, sdo[i]}, 32'd0);
  endtask

  initial begin
    int u0, a0, k;
    // reset asserted between clock edges, checked before the next edge
    #2 tb_n_rst = 1'b0;
    #1 check_rst(0);
    check_rst(1);
    repeat (3) @(negedge tb_clk);
    tb_n_rst = 1'b1;

    // single frame, SCK_HALF=1
    tx_en[0] = 1'b1;
    send(0, 32'hA5A50F0F);
    wait_rdy(0);
    tx_en[0] = 1'b0;
    drain(0);

    // streaming, SCK_HALF=3
    tx_en[1] = 1'b1;
    send(1, 32'h12345678);
    send(1, 32'h9ABCDEF0);
    send(1, 32'h0000FFFF);
    wait_rdy(1);
    tx_en[1] = 1'b0;
    drain(1);
    chk("stream_underrun", ucnt[1], 32'd0);

    // underrun: one sample, then nothing
    u0 = ucnt[0];
    a0 = uat0[0];
    tx_en[0] = 1'b1;
    send(0, 32'hC3C33C3C);
    expq.push_back(32'd0);
    k = 0;
    while (ucnt[0] == u0 && k < 3000) begin
      @(negedge tb_clk);
      k++;
    end
    tx_en[0] = 1'b0;
    drain(0);
    chk("underrun_pulses", ucnt[0] - u0, 32'd1);
    chk("underrun_slot0", uat0[0] - a0, 32'd1);

    // disable mid-frame (around slot 5): frame still completes
    tx_en[1] = 1'b1;
    send(1, 32'h0F1E2D3C);
    wait_rdy(1);
    repeat (5 * 2 * 3) @(negedge tb_clk);
    tx_en[1] = 1'b0;
    drain(1);

    // reset around slot 20, then a fresh frame with lead-in
    tx_en[0] = 1'b1;
    send(0, 32'hDEADBEEF);
    wait_rdy(0);
    repeat (40) @(negedge tb_clk);
    #1 tb_n_rst = 1'b0;
    #2 check_rst(0);
    expq.delete();
    @(negedge tb_clk);
    tb_n_rst = 1'b1;
    send(0, 32'h5A5AC3C3);
    wait_rdy(0);
    tx_en[0] = 1'b0;
    drain(0);

    chk("frames", nfr, 32'd8);
    chk("queue_empty", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
